// File: rtl/iob_cache_line_fill.sv
// Miss-side line-fill controller: latches the victim way, bursts one line from the
// back-end into that way's data memory, then commits tag/valid and updates the policy.
module iob_cache_line_fill #(
    parameter int N_WAYS        = 8,
    parameter int NWAYS_W       = $clog2(N_WAYS),
    parameter int NLINES_W      = 7,
    parameter int TAG_W         = 20,
    parameter int WORD_OFFSET_W = 3,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = TAG_W + NLINES_W + WORD_OFFSET_W
) (
    input  logic                              clk_i,
    input  logic                              reset,
    input  logic                              miss_i,
    input  logic [ADDR_W-1:0]                 miss_addr_i,
    input  logic [N_WAYS-1:0]                 way_select_i,
    input  logic [NWAYS_W-1:0]                way_select_bin_i,
    output logic                              be_req_o,
    output logic [ADDR_W-1:0]                 be_addr_o,
    input  logic                              be_ready_i,
    input  logic                              be_rvalid_i,
    input  logic [DATA_W-1:0]                 be_rdata_i,
    output logic [N_WAYS-1:0]                 data_we_o,
    output logic [NLINES_W+WORD_OFFSET_W-1:0] data_addr_o,
    output logic [DATA_W-1:0]                 data_wdata_o,
    output logic [N_WAYS-1:0]                 tag_we_o,
    output logic [TAG_W-1:0]                  tag_o,
    output logic                              repl_we_o,
    output logic [N_WAYS-1:0]                 repl_way_hit_o,
    output logic [NLINES_W-1:0]               repl_line_o,
    output logic [NWAYS_W-1:0]                way_bin_o,
    output logic                              busy_o,
    output logic                              fill_done_o,
    output logic [1:0]                        state_o
);

    // Handshakes: a back-end request is accepted on the edge where be_req_o & be_ready_i;
    // a read beat is consumed on any edge in FILL where be_rvalid_i is high (no back-pressure).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                     state, state_nx;
    logic [TAG_W-1:0]           tag_q;
    logic [NLINES_W-1:0]        line_q;
    logic [N_WAYS-1:0]          way_q;
    logic [NWAYS_W-1:0]         way_bin_q;
    logic [WORD_OFFSET_W-1:0]   cnt;
    logic                       busy_q;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tag_q     <= '0;
            line_q    <= '0;
            way_q     <= '0;
            way_bin_q <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= (state_nx != IDLE);
            if (state == IDLE && miss_i) begin
                tag_q     <= miss_addr_i[ADDR_W-1 -: TAG_W];
                line_q    <= miss_addr_i[WORD_OFFSET_W +: NLINES_W];
                way_q     <= way_select_i;
                way_bin_q <= way_select_bin_i;
            end
            // Counter wraps to zero on the last beat, so it is ready for the next fill.
            if (state == REQ && be_ready_i) begin
                cnt <= '0;
            end else if (state == FILL && be_rvalid_i) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        be_req_o       = 1'b0;
        data_we_o      = '0;
        tag_we_o       = '0;
        repl_we_o      = 1'b0;
        repl_way_hit_o = '0;
        fill_done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (miss_i) state_nx = REQ;
            end
            REQ: begin
                be_req_o = 1'b1;
                if (be_ready_i) state_nx = FILL;
            end
            FILL: begin
                data_we_o = way_q & {N_WAYS{be_rvalid_i}};
                if (be_rvalid_i && cnt == {WORD_OFFSET_W{1'b1}}) state_nx = COMMIT;
            end
            COMMIT: begin
                tag_we_o       = way_q;
                repl_we_o      = 1'b1;
                repl_way_hit_o = way_q;
                fill_done_o    = 1'b1;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign be_addr_o    = {tag_q, line_q, {WORD_OFFSET_W{1'b0}}};
    assign data_addr_o  = {line_q, cnt};
    assign data_wdata_o = be_rdata_i;
    assign tag_o        = tag_q;
    assign repl_line_o  = line_q;
    assign way_bin_o    = way_bin_q;
    assign busy_o       = busy_q;
    assign state_o      = state;

endmodule

// File: tb/tb_iob_cache_line_fill.sv
// Directed bench for iob_cache_line_fill: normal fill, delayed ready, beat gaps,
// ignored misses while busy, stray rvalid, and asynchronous reset mid-fill.
module tb_iob_cache_line_fill;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        miss_i;
    logic [29:0] miss_addr_i;
    logic [7:0]  way_select_i;
    logic [2:0]  way_select_bin_i;
    logic        be_req_o;
    logic [29:0] be_addr_o;
    logic        be_ready_i;
    logic        be_rvalid_i;
    logic [31:0] be_rdata_i;
    logic [7:0]  data_we_o;
    logic [9:0]  data_addr_o;
    logic [31:0] data_wdata_o;
    logic [7:0]  tag_we_o;
    logic [19:0] tag_o;
    logic        repl_we_o;
    logic [7:0]  repl_way_hit_o;
    logic [6:0]  repl_line_o;
    logic [2:0]  way_bin_o;
    logic        busy_o;
    logic        fill_done_o;
    logic [1:0]  state_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0;

    iob_cache_line_fill dut (
        .clk_i(clk_i), .reset(reset), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
        .way_select_i(way_select_i), .way_select_bin_i(way_select_bin_i),
        .be_req_o(be_req_o), .be_addr_o(be_addr_o), .be_ready_i(be_ready_i),
        .be_rvalid_i(be_rvalid_i), .be_rdata_i(be_rdata_i),
        .data_we_o(data_we_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .tag_we_o(tag_we_o), .tag_o(tag_o), .repl_we_o(repl_we_o),
        .repl_way_hit_o(repl_way_hit_o), .repl_line_o(repl_line_o),
        .way_bin_o(way_bin_o), .busy_o(busy_o), .fill_done_o(fill_done_o),
        .state_o(state_o)
    );

    // clock / cycle counter
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a miss in IDLE, latch it, and check the REQ-state outputs.
    task automatic issue_miss(input logic [19:0] tag, input logic [6:0] line, input logic [2:0] off,
                              input logic [7:0] way, input logic [2:0] bin, input logic ready);
        miss_addr_i      = {tag, line, off};
        way_select_i     = way;
        way_select_bin_i = bin;
        be_ready_i       = ready;
        miss_i           = 1'b1;
        #1;
        check("idle_busy", busy_o, 1'b0);
        tick();
        miss_i = 1'b0;
        #1;
        check("req_be_req", be_req_o, 1'b1);
        check("req_be_addr", be_addr_o, {tag, line, 3'b000});
        check("req_way_bin", way_bin_o, bin);
        check("req_busy", busy_o, 1'b1);
        check("req_no_we", data_we_o, 8'h00);
    endtask

    // Deliver n beats starting at beat 0 of FILL; optional idle gaps and a stray miss.
    task automatic beats(input logic [6:0] line, input logic [7:0] way, input logic [31:0] base,
                         input int n, input int gap, input int intrude_at);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap && i > 0; g++) begin
                be_rvalid_i = 1'b0;
                #1;
                check("gap_we", data_we_o, 8'h00);
                check("gap_addr", data_addr_o, {line, i[2:0]});
                tick();
            end
            be_rvalid_i = 1'b1;
            be_rdata_i  = base + 32'(i);
            if (i == intrude_at) begin
                miss_i           = 1'b1;
                miss_addr_i      = 30'h3FFF_FFFF;
                way_select_i     = 8'h80;
                way_select_bin_i = 3'd7;
            end
            #1;
            check("beat_we", data_we_o, way);
            check("beat_addr", data_addr_o, {line, i[2:0]});
            check("beat_wdata", data_wdata_o, base + 32'(i));
            tick();
            miss_i = 1'b0;
        end
        be_rvalid_i = 1'b0;
    endtask

    task automatic commit_check(input logic [19:0] tag, input logic [6:0] line,
                                input logic [7:0] way, input logic [2:0] bin);
        be_rvalid_i = 1'b0;
        #1;
        check("cm_tag_we", tag_we_o, way);
        check("cm_tag", tag_o, tag);
        check("cm_repl_we", repl_we_o, 1'b1);
        check("cm_way_hit", repl_way_hit_o, way);
        check("cm_line", repl_line_o, line);
        check("cm_done", fill_done_o, 1'b1);
        check("cm_no_we", data_we_o, 8'h00);
        check("cm_state", state_o, 2'd3);
        tick();
        #1;
        check("post_done", fill_done_o, 1'b0);
        check("post_tag_we", tag_we_o, 8'h00);
        check("post_repl_we", repl_we_o, 1'b0);
        check("post_busy", busy_o, 1'b0);
        check("post_way_bin", way_bin_o, bin);
        check("post_line", repl_line_o, line);
    endtask

    initial begin
        reset = 1'b1; miss_i = 1'b0; miss_addr_i = '0; way_select_i = '0;
        way_select_bin_i = '0; be_ready_i = 1'b0; be_rvalid_i = 1'b0; be_rdata_i = '0;
        #3;
        check("rst_busy", busy_o, 1'b0);
        check("rst_req", be_req_o, 1'b0);
        check("rst_addr", be_addr_o, 30'h0);
        check("rst_tag_we", tag_we_o, 8'h00);
        check("rst_repl_we", repl_we_o, 1'b0);
        check("rst_done", fill_done_o, 1'b0);
        check("rst_state", state_o, 2'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Normal fill, ready in the same cycle as the request, back-to-back beats.
        issue_miss(20'h12345, 7'h05, 3'h3, 8'h10, 3'd4, 1'b1);
        t0 = cyc;
        tick();
        beats(7'h05, 8'h10, 32'hA0, 8, 0, -1);
        // REQ + 8 beats + COMMIT: fill_done_o is in the 10th cycle after the latch edge.
        check("latency", cyc - t0, 9);
        commit_check(20'h12345, 7'h05, 8'h10, 3'd4);

        // Delayed ready with stray rvalid in REQ, then beats with 1-cycle gaps.
        issue_miss(20'h12345, 7'h05, 3'h7, 8'h01, 3'd0, 1'b0);
        be_rvalid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("wait_req", be_req_o, 1'b1);
            check("wait_addr", be_addr_o, {20'h12345, 7'h05, 3'b000});
            check("wait_we", data_we_o, 8'h00);
        end
        be_ready_i = 1'b1;
        tick();
        be_rvalid_i = 1'b0;
        #1;
        check("fill_cnt0", data_addr_o, {7'h05, 3'd0});
        beats(7'h05, 8'h01, 32'hB0, 8, 1, -1);
        commit_check(20'h12345, 7'h05, 8'h01, 3'd0);

        // Stray miss and way_select change during FILL must not disturb the fill.
        issue_miss(20'hABCDE, 7'h11, 3'h0, 8'h04, 3'd2, 1'b1);
        tick();
        beats(7'h11, 8'h04, 32'hC0, 8, 0, 2);
        commit_check(20'hABCDE, 7'h11, 8'h04, 3'd2);

        // rvalid in IDLE: no writes, counter stays at zero.
        be_rvalid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("idle_we", data_we_o, 8'h00);
            check("idle_cnt", data_addr_o, {7'h11, 3'd0});
            tick();
        end
        be_rvalid_i = 1'b0;

        // Asynchronous reset after 3 beats; partial line never committed.
        issue_miss(20'h55555, 7'h22, 3'h1, 8'h02, 3'd1, 1'b1);
        tick();
        beats(7'h22, 8'h02, 32'hD0, 3, 0, -1);
        be_rvalid_i = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("ar_busy", busy_o, 1'b0);
        check("ar_we", data_we_o, 8'h00);
        check("ar_req", be_req_o, 1'b0);
        check("ar_addr", be_addr_o, 30'h0);
        check("ar_daddr", data_addr_o, 10'h0);
        check("ar_way_bin", way_bin_o, 3'd0);
        check("ar_state", state_o, 2'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ar_tag_we", tag_we_o, 8'h00);
            check("ar_repl_we", repl_we_o, 1'b0);
        end
        reset = 1'b0;
        be_rvalid_i = 1'b0;
        tick();
        issue_miss(20'h0F0F0, 7'h7F, 3'h5, 8'h08, 3'd3, 1'b1);
        tick();
        beats(7'h7F, 8'h08, 32'hE0, 8, 0, -1);
        commit_check(20'h0F0F0, 7'h7F, 8'h08, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog in case the DUT never returns.
    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
